// File: rtl/testblock_arb_pkg.sv
// Shared types and helpers for the testblock kernel arbiter.
//   MAX_PORTS   : largest number of stream pairs an arbiter instance may have
//   PORT_W      : index width, $clog2(max(MAX_PORTS,2))
//   port_idx_t  : port index carried through the tag FIFO
//   arb_state_t : request-side FSM states
//   rr_pick     : round-robin winner search starting at a pointer, with wrap
package testblock_arb_pkg;

  localparam int MAX_PORTS = 8;
  // Sized for the largest legal port count so a single index type serves every instance.
  localparam int PORT_W = $clog2((MAX_PORTS < 2) ? 2 : MAX_PORTS);

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } arb_state_t;

  // First requesting port at or above ptr, wrapping modulo n. Returns 0 when
  // nothing requests; callers only use the result when some request is set.
  function automatic port_idx_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                        input port_idx_t             ptr,
                                        input int                    n);
    port_idx_t win;
    port_idx_t cand;
    logic      found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      cand = port_idx_t'((int'(ptr) + k) % n);
      if (k < n && !found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/testblock_tag_fifo.sv
// Tag FIFO recording which input port owns each packet inside the kernel.
//   ce_clk, ce_rst : clock, asynchronous active-high reset
//   push, push_tag : write a port index (ignored when full)
//   pop            : discard the head entry (ignored when empty)
//   head           : oldest stored port index
//   full, empty    : derived from the registered count
//   count          : registered number of stored entries
module testblock_tag_fifo
  import testblock_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     ce_clk,
  input  logic                     ce_rst,
  input  logic                     push,
  input  port_idx_t                push_tag,
  input  logic                     pop,
  output port_idx_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  port_idx_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge ce_clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/testblock_kernel_arb.sv
// Packet-level round-robin arbiter sharing one processing kernel between
// NUM_PORTS sample streams, with ordered routing of results back to the
// port that sent each packet.
//   ce_clk, ce_rst         : clock, asynchronous active-high reset
//   port_en                : per-port arbitration enable
//   s_in_*                 : NUM_PORTS input streams, port i at [ITEM_W*i +: ITEM_W]
//   m_kern_*               : granted stream towards the kernel
//   s_kern_*               : kernel results
//   m_out_*                : NUM_PORTS routed result streams
//   inflight               : packets granted but not yet fully returned
//   err_orphan             : sticky, kernel produced data with no owner recorded
module testblock_kernel_arb
  import testblock_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ITEM_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                          ce_clk,
  input  logic                          ce_rst,
  input  logic [NUM_PORTS-1:0]          port_en,
  input  logic [ITEM_W*NUM_PORTS-1:0]   s_in_tdata,
  input  logic [NUM_PORTS-1:0]          s_in_tlast,
  input  logic [NUM_PORTS-1:0]          s_in_tvalid,
  output logic [NUM_PORTS-1:0]          s_in_tready,
  output logic [ITEM_W-1:0]             m_kern_tdata,
  output logic                          m_kern_tlast,
  output logic                          m_kern_tvalid,
  input  logic                          m_kern_tready,
  input  logic [ITEM_W-1:0]             s_kern_tdata,
  input  logic                          s_kern_tlast,
  input  logic                          s_kern_tvalid,
  output logic                          s_kern_tready,
  output logic [ITEM_W*NUM_PORTS-1:0]   m_out_tdata,
  output logic [NUM_PORTS-1:0]          m_out_tlast,
  output logic [NUM_PORTS-1:0]          m_out_tvalid,
  input  logic [NUM_PORTS-1:0]          m_out_tready,
  output logic [$clog2(TAG_DEPTH):0]    inflight,
  output logic                          err_orphan
);

  arb_state_t           state, state_nxt;
  port_idx_t            gnt, gnt_nxt;
  port_idx_t            rr_ptr, rr_ptr_nxt;
  logic [NUM_PORTS-1:0] req;
  logic                 push, pop, full, empty;
  port_idx_t            head;

  assign req = s_in_tvalid & port_en;

  // Request side: one arbitration cycle in IDLE, then the granted stream is
  // wired straight through to the kernel until its last beat is accepted.
  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    rr_ptr_nxt    = rr_ptr;
    push          = 1'b0;
    m_kern_tdata  = '0;
    m_kern_tlast  = 1'b0;
    m_kern_tvalid = 1'b0;
    s_in_tready   = '0;
    case (state)
      IDLE: begin
        if (|req && !full) begin
          push      = 1'b1;
          gnt_nxt   = rr_pick(MAX_PORTS'(req), rr_ptr, NUM_PORTS);
          state_nxt = FWD;
        end
      end
      FWD: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (gnt == port_idx_t'(i)) begin
            m_kern_tdata   = s_in_tdata[ITEM_W*i +: ITEM_W];
            m_kern_tlast   = s_in_tlast[i];
            m_kern_tvalid  = s_in_tvalid[i];
            s_in_tready[i] = m_kern_tready;
          end
        end
        if (m_kern_tvalid && m_kern_tready && m_kern_tlast) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (gnt == port_idx_t'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      rr_ptr     <= rr_ptr_nxt;
      err_orphan <= err_orphan | (empty & s_kern_tvalid);
    end
  end

  // Return side: the FIFO head names the owner of the result currently
  // leaving the kernel; everything else stays quiet so results stay ordered.
  always_comb begin
    m_out_tvalid  = '0;
    m_out_tdata   = '0;
    m_out_tlast   = '0;
    s_kern_tready = 1'b0;
    if (!empty) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (head == port_idx_t'(i)) begin
          m_out_tvalid[i]                = s_kern_tvalid;
          m_out_tdata[ITEM_W*i +: ITEM_W] = s_kern_tdata;
          m_out_tlast[i]                 = s_kern_tlast;
          s_kern_tready                  = m_out_tready[i];
        end
      end
    end
  end

  assign pop = s_kern_tvalid & s_kern_tready & s_kern_tlast;

  testblock_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .ce_clk   (ce_clk),
    .ce_rst   (ce_rst),
    .push     (push),
    .push_tag (gnt_nxt),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (inflight)
  );

endmodule
